// File: rtl/kbd_cmd_sched_pkg.sv
// kbd_cmd_sched_pkg: PS/2 command/response codes and sequencer enums
package kbd_cmd_sched_pkg;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_LED     = 8'hED;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR = 8'hFC;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACK, ST_WAIT_BAT} st_e;
  typedef enum logic [1:0] {SRC_INIT, SRC_HOST, SRC_LED} src_e;
endpackage

// File: rtl/kbd_cmd_sched_rx_fifo.sv
// kbd_rx_fifo: synchronous byte FIFO with sticky overflow flag cleared by pop
module kbd_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       valid_o,
  output logic       ovf_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic empty, full, do_push, do_pop, ovf_q, ovf_d;
  always_comb begin
    empty = wr_q == rd_q;
    full = wr_q == (rd_q ^ {1'b1, {AW{1'b0}}});
    do_pop = pop_i && !empty;
    do_push = push_i && (!full || do_pop);
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
    ovf_d = (ovf_q && !pop_i) || (push_i && !do_push);
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end
  assign dout_o = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
  assign valid_o = !empty;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/kbd_cmd_sched.sv
// kbd_cmd_sched: PS/2 keyboard command sequencer with retry, BAT tracking and RX scancode FIFO
module kbd_cmd_sched
  import kbd_cmd_sched_pkg::*;
#(
  parameter int TIMEOUT = 500000,
  parameter int MAX_RETRY = 3,
  parameter int FIFO_DEPTH = 8,
  parameter bit INIT_ON_RST = 1'b1
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       host_req_i,
  input  logic [7:0] host_cmd_i,
  input  logic [7:0] host_arg_i,
  input  logic       host_has_arg_i,
  output logic       host_busy_o,
  output logic       host_done_o,
  output logic       host_fail_o,
  input  logic       led_req_i,
  input  logic [2:0] led_mask_i,
  input  logic       rx_rd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ovf_o,
  output logic       phy_cmd_o,
  output logic [7:0] phy_dat_o,
  input  logic [7:0] phy_kbd_i,
  input  logic       phy_hit_i,
  input  logic       phy_err_i,
  input  logic       phy_ready_i
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  st_e state_q;
  src_e src_q;
  logic [7:0] byte0_q, byte1_q, host_cmd_q, host_arg_q, phy_dat_q;
  logic [2:0] led_mask_q;
  logic has_arg_q, arg_phase_q, host_has_arg_q, host_busy_q, led_pend_q, init_pend_q;
  logic host_done_q, host_fail_q, phy_cmd_q, err_q;
  logic [RW-1:0] retry_q;
  logic [TW-1:0] timer_q;
  logic in_ack, in_bat, rsp_ack, rsp_rsd, rsp_bok, rsp_bko, tmo;
  logic retry_ev, can_retry, next_arg, to_bat, done_ev, fail_ev, push;
  always_comb begin
    in_ack = state_q == ST_WAIT_ACK;
    in_bat = state_q == ST_WAIT_BAT;
    rsp_ack = phy_hit_i && phy_kbd_i == RSP_ACK;
    rsp_rsd = phy_hit_i && phy_kbd_i == RSP_RESEND;
    rsp_bok = phy_hit_i && phy_kbd_i == RSP_BAT_OK;
    rsp_bko = phy_hit_i && phy_kbd_i == RSP_BAT_ERR;
    tmo = timer_q == TW'(TIMEOUT - 1);
    retry_ev = in_ack && (rsp_rsd || (!rsp_ack && (tmo || (phy_err_i && !err_q))));
    can_retry = retry_q < RW'(MAX_RETRY);
    next_arg = in_ack && rsp_ack && !arg_phase_q && has_arg_q;
    to_bat = in_ack && rsp_ack && !next_arg && byte0_q == CMD_RESET;
    done_ev = (in_ack && rsp_ack && !next_arg && !to_bat) || (in_bat && rsp_bok);
    fail_ev = (retry_ev && !can_retry) || (in_bat && !rsp_bok && (rsp_bko || tmo));
    push = phy_hit_i && (in_ack ? !(rsp_ack || rsp_rsd) : in_bat ? !(rsp_bok || rsp_bko) : 1'b1);
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      src_q <= SRC_INIT;
      byte0_q <= '0;
      byte1_q <= '0;
      host_cmd_q <= '0;
      host_arg_q <= '0;
      phy_dat_q <= '0;
      led_mask_q <= '0;
      has_arg_q <= 1'b0;
      arg_phase_q <= 1'b0;
      host_has_arg_q <= 1'b0;
      host_busy_q <= 1'b0;
      led_pend_q <= 1'b0;
      init_pend_q <= INIT_ON_RST;
      host_done_q <= 1'b0;
      host_fail_q <= 1'b0;
      phy_cmd_q <= 1'b0;
      err_q <= 1'b0;
      retry_q <= '0;
      timer_q <= '0;
    end else begin
      phy_cmd_q <= 1'b0;
      host_done_q <= 1'b0;
      host_fail_q <= 1'b0;
      err_q <= phy_err_i;
      if (host_req_i && !host_busy_q) begin
        host_busy_q <= 1'b1;
        host_cmd_q <= host_cmd_i;
        host_arg_q <= host_arg_i;
        host_has_arg_q <= host_has_arg_i;
      end
      if (led_req_i) begin
        led_pend_q <= 1'b1;
        led_mask_q <= led_mask_i;
      end
      if ((in_ack || in_bat) && !tmo) timer_q <= timer_q + TW'(1);
      case (state_q)
        ST_IDLE: begin
          if (init_pend_q || host_busy_q || led_pend_q) begin
            state_q <= ST_ISSUE;
            retry_q <= '0;
            arg_phase_q <= 1'b0;
          end
          if (init_pend_q) begin
            init_pend_q <= 1'b0;
            src_q <= SRC_INIT;
            byte0_q <= CMD_RESET;
            has_arg_q <= 1'b0;
          end else if (host_busy_q) begin
            src_q <= SRC_HOST;
            byte0_q <= host_cmd_q;
            byte1_q <= host_arg_q;
            has_arg_q <= host_has_arg_q;
          end else if (led_pend_q) begin
            led_pend_q <= led_req_i;
            src_q <= SRC_LED;
            byte0_q <= CMD_LED;
            byte1_q <= {5'b0, led_mask_q};
            has_arg_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (phy_ready_i) begin
            phy_cmd_q <= 1'b1;
            phy_dat_q <= arg_phase_q ? byte1_q : byte0_q;
            timer_q <= '0;
            state_q <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (next_arg) begin
            arg_phase_q <= 1'b1;
            retry_q <= '0;
            state_q <= ST_ISSUE;
          end else if (to_bat) begin
            timer_q <= '0;
            state_q <= ST_WAIT_BAT;
          end else if (retry_ev && can_retry) begin
            retry_q <= retry_q + RW'(1);
            state_q <= ST_ISSUE;
          end
        end
        default: ;
      endcase
      if (done_ev || fail_ev) begin
        state_q <= ST_IDLE;
        if (src_q == SRC_HOST) begin
          host_done_q <= done_ev;
          host_fail_q <= fail_ev;
          host_busy_q <= 1'b0;
        end
      end
    end
  end
  kbd_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (push),
    .din_i   (phy_kbd_i),
    .pop_i   (rx_rd_i),
    .dout_o  (rx_data_o),
    .valid_o (rx_valid_o),
    .ovf_o   (rx_ovf_o)
  );
  assign host_busy_o = host_busy_q;
  assign host_done_o = host_done_q;
  assign host_fail_o = host_fail_q;
  assign phy_cmd_o = phy_cmd_q;
  assign phy_dat_o = phy_dat_q;
endmodule
